// File: rtl/pll_ctrl_pkg.sv
// Shared types for the PLL lock supervisor: FSM state encoding and synchroniser depth.
package pll_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_SETTLE,
        ST_MEASURE,
        ST_LOCKED
    } pll_state_e;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/pll_edge_sync.sv
// Brings an asynchronous clock-like input into the CK domain and emits a one-cycle pulse per rising edge.
module pll_edge_sync
    import pll_ctrl_pkg::*;
(
    input  logic ck_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge ck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL supervisor: powers the PLL up, waits a settle time, then counts CK_FB edges per CK_REF window to decide lock.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned WIN     = 64,
    parameter int unsigned TOL     = 2,
    parameter int unsigned CW      = 8,
    parameter int unsigned SETTLE  = 1024,
    parameter int unsigned LOCK_N  = 4,
    parameter int unsigned TMO_N   = 16,
    parameter int unsigned REF_TMO = 4096
) (
    input  logic          CK,
    input  logic          RST_N,
    input  logic          EN,
    input  logic          CK_REF,
    input  logic          CK_FB,
    output logic          PWRUP,
    output logic          LOCK,
    output logic          TIMEOUT,
    output logic [CW-1:0] FB_CNT,
    output logic          MEAS_VLD
);

    localparam int unsigned SCW = $clog2(SETTLE + 1);
    localparam int unsigned RCW = $clog2(WIN + 1);
    localparam int unsigned GCW = $clog2(LOCK_N + 1);
    localparam int unsigned WCW = $clog2(TMO_N + 1);
    localparam int unsigned DCW = $clog2(REF_TMO + 1);

    pll_state_e     state_q;
    logic [SCW-1:0] settle_cnt_q;
    logic [RCW-1:0] ref_cnt_q;
    logic [CW-1:0]  fb_cnt_q;
    logic [GCW-1:0] good_cnt_q;
    logic [WCW-1:0] win_cnt_q;
    logic [DCW-1:0] wdog_q;
    logic           armed_q;
    logic           pwrup_q;
    logic           lock_q;
    logic           timeout_q;
    logic [CW-1:0]  fb_last_q;
    logic           meas_vld_q;

    logic           ref_rise;
    logic           fb_rise;
    logic [CW-1:0]  fb_cnt_d;
    logic [GCW-1:0] good_cnt_d;
    logic [WCW-1:0] win_cnt_d;
    logic           win_good_d;
    logic           win_close_d;
    logic           wdog_exp_d;

    pll_edge_sync u_ref_sync (.ck_i(CK), .rst_ni(RST_N), .d_i(CK_REF), .rise_o(ref_rise));
    pll_edge_sync u_fb_sync  (.ck_i(CK), .rst_ni(RST_N), .d_i(CK_FB),  .rise_o(fb_rise));

    always_comb begin
        fb_cnt_d    = (fb_cnt_q == '1) ? fb_cnt_q : fb_cnt_q + CW'(1);
        good_cnt_d  = (good_cnt_q == GCW'(LOCK_N)) ? good_cnt_q : good_cnt_q + GCW'(1);
        win_cnt_d   = (win_cnt_q == WCW'(TMO_N)) ? win_cnt_q : win_cnt_q + WCW'(1);
        win_good_d  = (fb_cnt_q >= CW'(WIN - TOL)) && (fb_cnt_q <= CW'(WIN + TOL));
        win_close_d = ref_rise && !armed_q && (ref_cnt_q == RCW'(WIN - 1));
        wdog_exp_d  = !ref_rise && (wdog_q == DCW'(REF_TMO - 1));
    end

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_OFF;
            settle_cnt_q <= '0;
            ref_cnt_q    <= '0;
            fb_cnt_q     <= '0;
            good_cnt_q   <= '0;
            win_cnt_q    <= '0;
            wdog_q       <= '0;
            armed_q      <= 1'b0;
            pwrup_q      <= 1'b0;
            lock_q       <= 1'b0;
            timeout_q    <= 1'b0;
            fb_last_q    <= '0;
            meas_vld_q   <= 1'b0;
        end else begin
            meas_vld_q <= 1'b0;
            if (!EN) begin
                state_q      <= ST_OFF;
                settle_cnt_q <= '0;
                ref_cnt_q    <= '0;
                fb_cnt_q     <= '0;
                good_cnt_q   <= '0;
                win_cnt_q    <= '0;
                wdog_q       <= '0;
                armed_q      <= 1'b0;
                pwrup_q      <= 1'b0;
                lock_q       <= 1'b0;
                timeout_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_OFF: begin
                        state_q      <= ST_SETTLE;
                        pwrup_q      <= 1'b1;
                        settle_cnt_q <= '0;
                    end
                    ST_SETTLE: begin
                        if (settle_cnt_q == SCW'(SETTLE - 1)) begin
                            state_q    <= ST_MEASURE;
                            armed_q    <= 1'b1;
                            ref_cnt_q  <= '0;
                            fb_cnt_q   <= '0;
                            good_cnt_q <= '0;
                            win_cnt_q  <= '0;
                            wdog_q     <= '0;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + SCW'(1);
                        end
                    end
                    default: begin
                        // Lost reference aborts the open window and re-arms on the next ref edge.
                        if (wdog_exp_d) begin
                            state_q    <= ST_MEASURE;
                            lock_q     <= 1'b0;
                            timeout_q  <= 1'b1;
                            armed_q    <= 1'b1;
                            ref_cnt_q  <= '0;
                            fb_cnt_q   <= '0;
                            good_cnt_q <= '0;
                            win_cnt_q  <= '0;
                            wdog_q     <= '0;
                        end else begin
                            wdog_q <= ref_rise ? '0 : wdog_q + DCW'(1);
                            if (armed_q) begin
                                if (ref_rise) begin
                                    armed_q   <= 1'b0;
                                    ref_cnt_q <= '0;
                                    fb_cnt_q  <= '0;
                                end
                            end else if (win_close_d) begin
                                fb_last_q  <= fb_cnt_q;
                                meas_vld_q <= 1'b1;
                                ref_cnt_q  <= '0;
                                fb_cnt_q   <= fb_rise ? CW'(1) : '0;
                                good_cnt_q <= win_good_d ? good_cnt_d : '0;
                                if (state_q == ST_LOCKED) begin
                                    if (!win_good_d) begin
                                        state_q   <= ST_MEASURE;
                                        lock_q    <= 1'b0;
                                        win_cnt_q <= '0;
                                    end else begin
                                        win_cnt_q <= win_cnt_d;
                                    end
                                end else begin
                                    win_cnt_q <= win_cnt_d;
                                    if (win_good_d && (good_cnt_d == GCW'(LOCK_N))) begin
                                        state_q <= ST_LOCKED;
                                        lock_q  <= 1'b1;
                                    end else if (win_cnt_d == WCW'(TMO_N)) begin
                                        timeout_q <= 1'b1;
                                    end
                                end
                            end else begin
                                if (ref_rise) ref_cnt_q <= ref_cnt_q + RCW'(1);
                                if (fb_rise)  fb_cnt_q  <= fb_cnt_d;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign PWRUP    = pwrup_q;
    assign LOCK     = lock_q;
    assign TIMEOUT  = timeout_q;
    assign FB_CNT   = fb_last_q;
    assign MEAS_VLD = meas_vld_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scoreboard bench for pll_lock_ctrl: per-window expectations are queued as stimulus is driven and popped on MEAS_VLD.
module tb_pll_lock_ctrl;

    localparam int WIN     = 64;
    localparam int TOL     = 2;
    localparam int CW      = 8;
    localparam int SETTLE  = 1024;
    localparam int LOCK_N  = 4;
    localparam int TMO_N   = 16;
    localparam int REF_TMO = 4096;

    logic          CK = 1'b0;
    logic          RST_N, EN, CK_REF, CK_FB;
    logic          PWRUP, LOCK, TIMEOUT, MEAS_VLD;
    logic [CW-1:0] FB_CNT;

    pll_lock_ctrl #(
        .WIN(WIN), .TOL(TOL), .CW(CW), .SETTLE(SETTLE),
        .LOCK_N(LOCK_N), .TMO_N(TMO_N), .REF_TMO(REF_TMO)
    ) dut (
        .CK(CK), .RST_N(RST_N), .EN(EN), .CK_REF(CK_REF), .CK_FB(CK_FB),
        .PWRUP(PWRUP), .LOCK(LOCK), .TIMEOUT(TIMEOUT), .FB_CNT(FB_CNT), .MEAS_VLD(MEAS_VLD)
    );

    always #5 CK = ~CK;

    typedef struct {
        int fb;
        bit lock;
        bit tmo;
        int at;
    } exp_t;

    exp_t sb_q[$];
    exp_t r;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   m_good, m_win;
    bit   m_locked, m_tmo;
    int   t_en, t_ref;

    always @(posedge CK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_good = 0; m_win = 0; m_locked = 0; m_tmo = 0;
    endfunction

    function automatic void model_wdog();
        m_good = 0; m_win = 0; m_locked = 0; m_tmo = 1;
    endfunction

    // Reference lock decision for one completed window of nfb feedback edges.
    function automatic void push_window(input int nfb, input int at);
        bit good;
        good = (nfb >= WIN - TOL) && (nfb <= WIN + TOL);
        if (m_locked) begin
            if (!good) begin
                m_locked = 0; m_good = 0; m_win = 0;
            end else begin
                if (m_good < LOCK_N) m_good++;
                if (m_win < TMO_N) m_win++;
            end
        end else begin
            m_good = good ? ((m_good < LOCK_N) ? m_good + 1 : m_good) : 0;
            if (m_win < TMO_N) m_win++;
            if (m_good == LOCK_N) m_locked = 1;
            else if (m_win == TMO_N) m_tmo = 1;
        end
        sb_q.push_back('{fb: nfb, lock: m_locked, tmo: m_tmo, at: at});
    endfunction

    function automatic int edges_in(input int nfb, input int p);
        if (nfb >= WIN) return 1 + ((p < nfb - WIN) ? 1 : 0);
        return (p < nfb) ? 1 : 0;
    endfunction

    // One CK_REF period of 8 CK cycles; feedback rises at ticks 2 and 6, clear of the ref edge.
    task automatic drive_period(input int ne);
        for (int t = 0; t < 8; t++) begin
            CK_REF = (t < 4);
            CK_FB  = ((ne >= 1) && (t == 2 || t == 3)) || ((ne == 2) && (t >= 6));
            @(negedge CK);
        end
    endtask

    task automatic drive_window(input int nfb, input int at);
        push_window(nfb, at);
        for (int p = 0; p < WIN; p++) drive_period(edges_in(nfb, p));
    endtask

    task automatic idle(input int n);
        CK_REF = 1'b0;
        CK_FB  = 1'b0;
        repeat (n) @(negedge CK);
    endtask

    always begin
        @(posedge CK);
        #1;
        if (RST_N === 1'b1 && MEAS_VLD === 1'b1) begin
            check_eq("sb_pending", (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                r = sb_q.pop_front();
                if (r.at >= 0) check_eq("vld_cycle", cyc, r.at);
                check_eq("fb_cnt", FB_CNT, r.fb);
                @(posedge CK);
                #1;
                check_eq("vld_pulse", MEAS_VLD, 0);
                check_eq("lock_after_win", LOCK, r.lock);
                check_eq("tmo_after_win", TIMEOUT, r.tmo);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        RST_N = 1'b1; EN = 1'b0; CK_REF = 1'b0; CK_FB = 1'b0;
        model_reset();
        #2 RST_N = 1'b0;
        repeat (3) @(negedge CK);
        check_eq("rst_pwrup", PWRUP, 0);
        check_eq("rst_lock", LOCK, 0);
        check_eq("rst_timeout", TIMEOUT, 0);
        check_eq("rst_fb_cnt", FB_CNT, 0);
        check_eq("rst_meas_vld", MEAS_VLD, 0);
        RST_N = 1'b1;
        repeat (2) @(negedge CK);

        // Power-up, settle, first lock; a ref edge lands on the last SETTLE cycle and must be ignored.
        EN = 1'b1;
        t_en = cyc;
        #1 check_eq("pwrup_before_edge", PWRUP, 0);
        @(posedge CK); #1;
        check_eq("pwrup_next_cycle", PWRUP, 1);
        @(negedge CK);
        repeat (SETTLE - 3) @(negedge CK);
        drive_period(1);
        drive_window(64, t_en + SETTLE + 1 + 8 + 512);
        repeat (4) drive_window(64, -1);

        // Out-of-tolerance window while locked, then relock.
        drive_window(70, -1);
        repeat (4) drive_window(64, -1);

        // Tolerance edges: 66/62 good, 67/61 bad.
        drive_window(66, -1);
        drive_window(62, -1);
        drive_window(67, -1);
        drive_window(66, -1);
        drive_window(62, -1);
        drive_window(66, -1);
        drive_window(62, -1);
        drive_window(61, -1);
        repeat (4) drive_window(64, -1);

        // Reference stops while locked.
        CK_REF = 1'b1; CK_FB = 1'b0;
        t_ref = cyc;
        repeat (4) @(negedge CK);
        CK_REF = 1'b0;
        while (cyc < t_ref + 3 + REF_TMO - 1) begin
            @(posedge CK); #1;
        end
        check_eq("wdog_tmo_early", TIMEOUT, 0);
        check_eq("wdog_lock_early", LOCK, 1);
        @(posedge CK); #1;
        check_eq("wdog_tmo", TIMEOUT, 1);
        check_eq("wdog_lock", LOCK, 0);
        check_eq("wdog_fb_held", FB_CNT, 64);
        check_eq("wdog_pwrup", PWRUP, 1);
        model_wdog();
        @(negedge CK);

        // Relock with TIMEOUT sticky, then drop EN mid-window.
        repeat (4) drive_window(64, -1);
        repeat (20) drive_period(1);
        EN = 1'b0;
        @(posedge CK); #1;
        check_eq("off_pwrup", PWRUP, 0);
        check_eq("off_lock", LOCK, 0);
        check_eq("off_timeout", TIMEOUT, 0);
        check_eq("off_fb_held", FB_CNT, 64);
        model_reset();
        @(negedge CK);
        idle(4);

        // Restart: first ref edge arrives on the first MEASURE cycle; then CK_FB dead.
        EN = 1'b1;
        t_en = cyc;
        repeat (SETTLE - 1) @(negedge CK);
        drive_window(0, t_en + SETTLE + 2 + 512);
        repeat (TMO_N - 1) drive_window(0, -1);
        drive_window(64, -1);
        repeat (10) drive_period(1);
        check_eq("pwrup_after_tmo", PWRUP, 1);
        check_eq("tmo_sticky", TIMEOUT, 1);

        // Asynchronous reset mid-window.
        #3 RST_N = 1'b0;
        #1;
        check_eq("arst_pwrup", PWRUP, 0);
        check_eq("arst_lock", LOCK, 0);
        check_eq("arst_timeout", TIMEOUT, 0);
        check_eq("arst_fb_cnt", FB_CNT, 0);
        check_eq("arst_meas_vld", MEAS_VLD, 0);
        @(negedge CK);
        CK_REF = 1'b0; CK_FB = 1'b0;
        RST_N = 1'b1;
        repeat (4) @(negedge CK);
        check_eq("sb_drain", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
